// File: rtl/seg7_pkg.sv
// Shared constants for the six-digit hh.mm.ss multiplexed display:
// segment patterns, edit-field encodings, digit slot indices and a BCD helper.
package seg7_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HR   = 2'd1;
  localparam logic [1:0] SEL_MI   = 2'd2;
  localparam logic [1:0] SEL_SE   = 2'd3;

  localparam logic [2:0] DIG_SE_ONES = 3'd0;
  localparam logic [2:0] DIG_SE_TENS = 3'd1;
  localparam logic [2:0] DIG_MI_ONES = 3'd2;
  localparam logic [2:0] DIG_MI_TENS = 3'd3;
  localparam logic [2:0] DIG_HR_ONES = 3'd4;
  localparam logic [2:0] DIG_HR_TENS = 3'd5;

  typedef enum logic {PH_VISIBLE = 1'b0, PH_HIDDEN = 1'b1} phase_e;

  // Returns {tens, ones}; exact for 0..59, inputs above that are shown as dashes anyway.
  function automatic logic [7:0] bin2bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'd0;
    for (int t = 1; t <= 6; t++) begin
      if (v >= 6'(t * 10)) tens = 4'(t);
    end
    ones = 4'(v - 6'(tens) * 6'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational 4-bit digit code to active-low 7-segment pattern; non-decimal codes blank.
module seg7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_disp.sv
// Six-digit hh.mm.ss scanner with per-frame input snapshot and edit-field blink.
// Optional HR_LEADING_BLANK_EN blanks the hour tens digit for hours below 10.
module seg7_scan_disp
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cnt_hr,
  input  logic [5:0] cnt_mi,
  input  logic [5:0] cnt_se,
  input  logic [1:0] blink_sel,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       dp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic          first_q, first_d;
  logic [5:0]    snap_hr_q, snap_hr_d;
  logic [5:0]    snap_mi_q, snap_mi_d;
  logic [5:0]    snap_se_q, snap_se_d;
  logic [1:0]    sel_q, sel_d;
  phase_e        phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [6:0]    seg_q, seg_d;
  logic [5:0]    an_q, an_d;
  logic          dp_q, dp_d;

  logic       scan_tick;
  logic       sel_chg;
  logic [5:0] fld_val;
  logic       fld_bad;
  logic [1:0] fld_sel;
  logic [7:0] fld_bcd;
  logic [3:0] dig_code;
  logic [6:0] dec_seg;
  logic       blank;

  seg7_dec u_dec (
    .code (dig_code),
    .seg  (dec_seg)
  );

  always_comb begin
    scan_tick = (presc_q == PW'(SCAN_DIV - 1));
    presc_d   = scan_tick ? '0 : presc_q + 1'b1;

    idx_d = idx_q;
    if (scan_tick) idx_d = (idx_q == DIG_HR_TENS) ? DIG_SE_ONES : idx_q + 3'd1;

    // Snapshot on the first tick so the very first frame is coherent too.
    first_d   = first_q && !scan_tick;
    snap_hr_d = snap_hr_q;
    snap_mi_d = snap_mi_q;
    snap_se_d = snap_se_q;
    if (scan_tick && (first_q || idx_q == DIG_HR_TENS)) begin
      snap_hr_d = cnt_hr;
      snap_mi_d = cnt_mi;
      snap_se_d = cnt_se;
    end

    sel_d   = blink_sel;
    sel_chg = (blink_sel != sel_q);
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    if (sel_chg) begin
      phase_d = PH_VISIBLE;
      bcnt_d  = '0;
    end else if (scan_tick) begin
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_d  = '0;
        phase_d = (phase_q == PH_VISIBLE) ? PH_HIDDEN : PH_VISIBLE;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end

    // Field selected by idx[2:1]: 0 seconds, 1 minutes, 2 hours.
    case (idx_d[2:1])
      2'd0:    begin fld_val = snap_se_d; fld_bad = (snap_se_d > 6'd59); fld_sel = SEL_SE; end
      2'd1:    begin fld_val = snap_mi_d; fld_bad = (snap_mi_d > 6'd59); fld_sel = SEL_MI; end
      default: begin fld_val = snap_hr_d; fld_bad = (snap_hr_d > 6'd23); fld_sel = SEL_HR; end
    endcase
    fld_bcd  = bin2bcd(fld_val);
    dig_code = idx_d[0] ? fld_bcd[7:4] : fld_bcd[3:0];

    blank = (phase_q == PH_HIDDEN) && !sel_chg && (blink_sel == fld_sel);
`ifdef HR_LEADING_BLANK_EN
    if (idx_d == DIG_HR_TENS && snap_hr_d < 6'd10) blank = 1'b1;
`endif

    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (scan_tick) begin
      if (blank) begin
        seg_d = SEG_BLANK;
        an_d  = 6'h3F;
        dp_d  = 1'b1;
      end else begin
        seg_d = fld_bad ? SEG_DASH : dec_seg;
        an_d  = ~(6'd1 << idx_d);
        dp_d  = !(idx_d == DIG_MI_ONES || idx_d == DIG_HR_ONES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q   <= '0;
      idx_q     <= DIG_SE_ONES;
      first_q   <= 1'b1;
      snap_hr_q <= '0;
      snap_mi_q <= '0;
      snap_se_q <= '0;
      sel_q     <= SEL_NONE;
      phase_q   <= PH_VISIBLE;
      bcnt_q    <= '0;
      seg_q     <= SEG_BLANK;
      an_q      <= 6'h3F;
      dp_q      <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      snap_hr_q <= snap_hr_d;
      snap_mi_q <= snap_mi_d;
      snap_se_q <= snap_se_d;
      sel_q     <= sel_d;
      phase_q   <= phase_d;
      bcnt_q    <= bcnt_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
